// File: rtl/connection_config_loader_pkg.sv
// Shared definitions for the serial configuration loaders (connection block, switch box, LUT):
// loader state encoding and configuration-size helpers.
package connection_config_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PARITY = 2'd2,
        ST_COMMIT = 2'd3
    } cfg_state_e;

    // Configuration bits held by one connection block.
    function automatic int unsigned cfg_nbits(input int unsigned w, input int unsigned controlin);
        return w * controlin;
    endfunction

    // Counter must reach NBITS itself, hence the +1.
    function automatic int unsigned cfg_cnt_width(input int unsigned nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/connection_config_loader_cfg_shift_reg.sv
// Shadow shift register for configuration loaders: LSB-first serial fill with synchronous
// clear and a running XOR of every bit shifted in since the last clear.
module cfg_shift_reg
    import connection_config_loader_pkg::*;
#(
    parameter int unsigned N = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         bit_in,
    output logic [N-1:0] data,
    output logic         parity
);

    logic [N-1:0] data_q, data_d;
    logic         parity_q, parity_d;

    always_comb begin
        data_d   = data_q;
        parity_d = parity_q;
        if (clr) begin
            data_d   = '0;
            parity_d = 1'b0;
        end else if (shift_en) begin
            // New bit enters at the top so the first bit sent ends up in bit 0.
            data_d   = {bit_in, data_q[N-1:1]};
            parity_d = parity_q ^ bit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q   <= '0;
            parity_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            parity_q <= parity_d;
        end
    end

    assign data   = data_q;
    assign parity = parity_q;

endmodule

// File: rtl/connection_config_loader.sv
// Serial configuration writer for one connection block; the active switch vector only changes on
// commit. Optional even-parity check on the stream is enabled by defining CFG_LOADER_PARITY_EN.
module connection_config_loader
    import connection_config_loader_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned CONTROLIN = 6
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cfg_start,
    input  logic                                 cfg_in,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    output logic [cfg_nbits(W, CONTROLIN)-1:0]   c,
    output logic                                 cfg_done,
    output logic                                 cfg_err
);

    localparam int unsigned NBITS = cfg_nbits(W, CONTROLIN);
    localparam int unsigned CNT_W = cfg_cnt_width(NBITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

    cfg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] c_q, c_d;
    logic             done_q, done_d;
    logic             sh_clr, sh_shift;
    logic [NBITS-1:0] shadow;
`ifdef CFG_LOADER_PARITY_EN
    logic             err_q, err_d;
    logic             shadow_par;
`else
    logic             shadow_par_unused;
`endif

    cfg_shift_reg #(
        .N(NBITS)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (sh_clr),
        .shift_en(sh_shift),
        .bit_in  (cfg_in),
        .data    (shadow),
`ifdef CFG_LOADER_PARITY_EN
        .parity  (shadow_par)
`else
        .parity  (shadow_par_unused)
`endif
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        done_d   = 1'b0;
        sh_clr   = 1'b0;
        sh_shift = 1'b0;
`ifdef CFG_LOADER_PARITY_EN
        err_d    = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    sh_clr  = 1'b1;
`ifdef CFG_LOADER_PARITY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                // A restart wins over any bit offered in the same cycle.
                if (cfg_start) begin
                    cnt_d  = '0;
                    sh_clr = 1'b1;
                end else if (cfg_valid) begin
                    sh_shift = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
`ifdef CFG_LOADER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_COMMIT;
`endif
                    end
                end
            end
`ifdef CFG_LOADER_PARITY_EN
            ST_PARITY: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    sh_clr  = 1'b1;
                    err_d   = 1'b0;
                end else if (cfg_valid) begin
                    if (shadow_par ^ cfg_in) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_COMMIT;
                    end
                end
            end
`endif
            ST_COMMIT: begin
                c_d     = shadow;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
`ifdef CFG_LOADER_PARITY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            done_q  <= done_d;
`ifdef CFG_LOADER_PARITY_EN
            err_q   <= err_d;
`endif
        end
    end

    assign cfg_ready = (state_q == ST_LOAD) || (state_q == ST_PARITY);
    assign c         = c_q;
    assign cfg_done  = done_q;
`ifdef CFG_LOADER_PARITY_EN
    assign cfg_err   = err_q;
`else
    assign cfg_err   = 1'b0;
`endif

endmodule

// File: tb/tb_connection_config_loader.sv
// Directed + randomized bench for connection_config_loader; the expected switch vector is simply
// the last word that completed a full load (and passed parity when CFG_LOADER_PARITY_EN is set).
module tb_connection_config_loader;

    localparam int NB = 48;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_start;
    logic          cfg_in;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [NB-1:0] c;
    logic          cfg_done;
    logic          cfg_err;

    int compared   = 0;
    int mismatched = 0;
    logic [NB-1:0] c_model;

    connection_config_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_start(cfg_start),
        .cfg_in   (cfg_in),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .c        (c),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %012h expected %012h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        tick();
        cfg_start = 1'b0;
        chk1("ready_after_start", cfg_ready, 1'b1);
        chk1("err_clear_on_start", cfg_err, 1'b0);
        chkc("c_held_on_start", c, c_model);
    endtask

    task automatic shift_bits(input logic [NB-1:0] data, input int n, input bit stall, output int stalls);
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            if (stall && ($urandom_range(0, 1) == 1)) begin
                cfg_valid = 1'b0;
                cfg_in    = 1'($urandom);
                tick();
                stalls++;
                chk1("ready_during_stall", cfg_ready, 1'b1);
            end
            chk1("ready_in_load", cfg_ready, 1'b1);
            cfg_valid = 1'b1;
            cfg_in    = data[i];
            tick();
            cfg_valid = 1'b0;
            chkc("c_held_while_shifting", c, c_model);
            chk1("no_done_while_shifting", cfg_done, 1'b0);
        end
    endtask

    // Completes a load whose data bits are all sent; start_in_commit pulses cfg_start in COMMIT.
    task automatic finish_load(input logic [NB-1:0] data, input bit start_in_commit);
`ifdef CFG_LOADER_PARITY_EN
        chk1("ready_for_parity", cfg_ready, 1'b1);
        cfg_valid = 1'b1;
        cfg_in    = ^data;
        tick();
        cfg_valid = 1'b0;
`endif
        chk1("commit_ready_low", cfg_ready, 1'b0);
        chkc("c_before_commit", c, c_model);
        cfg_start = start_in_commit;
        tick();
        cfg_start = 1'b0;
        c_model = data;
        chkc("c_after_commit", c, c_model);
        chk1("done_pulse", cfg_done, 1'b1);
        chk1("idle_after_commit", cfg_ready, 1'b0);
        tick();
        chk1("done_one_cycle", cfg_done, 1'b0);
        chk1("still_idle", cfg_ready, 1'b0);
    endtask

    task automatic full_load(input logic [NB-1:0] data, input bit stall, input string name);
        int st;
        start_load();
        shift_bits(data, NB, stall, st);
        finish_load(data, 1'b0);
        $display("%s: data=%012h stalls=%0d c=%012h", name, data, st, c);
    endtask

    initial begin
        int st;
        logic [63:0] rnd;
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        cfg_in    = 1'b1;
        c_model   = '0;
        tick();
        tick();
        chkc("reset_c", c, '0);
        chk1("reset_ready", cfg_ready, 1'b0);
        chk1("reset_done", cfg_done, 1'b0);
        chk1("reset_err", cfg_err, 1'b0);
        rst_n = 1'b1;
        tick();
        chk1("idle_ignores_valid", cfg_ready, 1'b0);
        chkc("idle_c_zero", c, '0);
        cfg_valid = 1'b0;
        $display("reset: c=%012h ready=%0b", c, cfg_ready);

        full_load(48'h0000_0000_0001, 1'b0, "basic");
        full_load(48'h0000_0000_0001, 1'b1, "stalled");
        full_load(48'h8000_0000_0000, 1'b1, "top_bit");

        // Abort after 20 bits, then a full load; start in COMMIT must be ignored.
        start_load();
        shift_bits(48'hFFFF_FFFF_FFFF, 20, 1'b0, st);
        start_load();
        shift_bits(48'hA5A5_A5A5_A5A5, NB, 1'b0, st);
        finish_load(48'hA5A5_A5A5_A5A5, 1'b1);
        $display("abort: data=%012h c=%012h", 48'hA5A5_A5A5_A5A5, c);

        // Reset after 30 bits discards everything.
        start_load();
        shift_bits(48'h1234_5678_9ABC, 30, 1'b0, st);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        c_model = '0;
        chkc("midload_reset_c", c, c_model);
        chk1("midload_reset_ready", cfg_ready, 1'b0);
        tick();
        chk1("midload_reset_idle", cfg_ready, 1'b0);
        $display("midload_reset: c=%012h", c);
        full_load(48'h0F0F_0000_F0F0, 1'b0, "after_reset");

        for (int k = 0; k < 4; k++) begin
            rnd = {$urandom, $urandom};
            full_load(rnd[NB-1:0], 1'b1, "random");
        end

`ifdef CFG_LOADER_PARITY_EN
        // Wrong parity bit: error, no commit.
        start_load();
        shift_bits(48'h3, NB, 1'b0, st);
        cfg_valid = 1'b1;
        cfg_in    = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk1("parity_err_set", cfg_err, 1'b1);
        chk1("parity_err_idle", cfg_ready, 1'b0);
        tick();
        chk1("parity_err_no_done", cfg_done, 1'b0);
        chkc("parity_err_c_kept", c, c_model);
        chk1("parity_err_sticky", cfg_err, 1'b1);
        $display("parity_bad: data=%012h err=%0b c=%012h", 48'h3, cfg_err, c);
        full_load(48'h3, 1'b0, "parity_good");
        chk1("parity_err_cleared", cfg_err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
